// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract unit: one full-adder slice reused for WIDTH cycles,
// sequenced by a start/busy/done handshake.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic             carry;
    logic [CW-1:0]    count;

    // Full adder built as two half-adder stages with the carries ORed.
    logic ha1_s, ha1_c, ha2_c, sum_bit, carry_nxt;
    assign ha1_s     = sh_a[0] ^ sh_b[0];
    assign ha1_c     = sh_a[0] & sh_b[0];
    assign sum_bit   = ha1_s ^ carry;
    assign ha2_c     = ha1_s & carry;
    assign carry_nxt = ha1_c | ha2_c;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            sh_a  <= '0;
            sh_b  <= '0;
            carry <= 1'b0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtract as A + ~B + 1: the +1 rides in on the carry.
                        sh_a  <= op_a;
                        sh_b  <= sub ? ~op_b : op_b;
                        carry <= sub;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum   <= {sum_bit, sum[WIDTH-1:1]};
                    carry <= carry_nxt;
                    sh_a  <= sh_a >> 1;
                    sh_b  <= sh_b >> 1;
                    if (count == LAST) begin
                        cout  <= carry_nxt;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: vector table plus handshake corner cases.
module tb_serial_add_ctrl;
    localparam int W = 8;

    logic         CLK, RST, start, sub;
    logic [W-1:0] op_a, op_b, sum;
    logic         busy, done, cout;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .start(start), .sub(sub),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
        .sum(sum), .cout(cout)
    );

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    always @(negedge CLK) if (done) done_cnt++;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int n;
        bit seen;
        @(negedge CLK);
        start = 1; op_a = v.a; op_b = v.b; sub = v.s;
        @(posedge CLK); #1;
        chk({nm, "_busy_on"}, busy, 1);
        @(negedge CLK);
        start = 0; op_a = ~v.a; op_b = ~v.b; sub = ~v.s;
        n = 0; seen = 0;
        while (!seen && n < 3 * W) begin
            @(posedge CLK); #1;
            n++;
            if (done) seen = 1;
        end
        chk({nm, "_latency"}, n, W);
        chk({nm, "_sum"}, sum, v.exp_sum);
        chk({nm, "_cout"}, cout, v.exp_cout);
        @(posedge CLK); #1;
        chk({nm, "_done_off"}, done, 0);
        chk({nm, "_busy_off"}, busy, 0);
    endtask

    vec_t vt[10];
    vec_t hv[3];

    initial begin
        int base, k;
        vt[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vt[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vt[3] = '{8'h10, 8'h01, 1'b1, 8'h0F, 1'b1};
        vt[4] = '{8'h01, 8'h02, 1'b1, 8'hFF, 1'b0};
        vt[5] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
        vt[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vt[7] = '{8'h80, 8'h80, 1'b1, 8'h00, 1'b1};
        vt[8] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0};
        vt[9] = '{8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1};
        hv[0] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0};
        hv[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        hv[2] = '{8'h80, 8'h80, 1'b1, 8'h00, 1'b1};

        RST = 1; start = 0; sub = 0; op_a = '0; op_b = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        @(negedge CLK); RST = 0;

        for (int i = 0; i < 10; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // Extra start requests during RUN (sampled at E3) and DONE are ignored.
        base = done_cnt;
        @(negedge CLK);
        start = 1; op_a = 8'h5A; op_b = 8'h3C; sub = 0;
        @(posedge CLK);
        for (int e = 1; e <= W + 2; e++) begin
            @(negedge CLK);
            if (e == 3) begin
                start = 1; op_a = 8'h11; op_b = 8'h22; sub = 1;
            end else if (e == W + 1) begin
                start = 1; op_a = 8'h33; op_b = 8'h44; sub = 1;
            end else begin
                start = 0;
            end
            @(posedge CLK); #1;
            if (e == W) begin
                chk("ign_done", done, 1);
                chk("ign_sum", sum, 8'h96);
                chk("ign_cout", cout, 0);
            end
        end
        chk("ign_busy_idle", busy, 0);
        chk("ign_one_done", done_cnt - base, 1);

        // Prime cout=1, then abort a run with an asynchronous mid-cycle reset.
        run_vec(vt[1], "pre_rst");
        @(negedge CLK);
        start = 1; op_a = 8'hF0; op_b = 8'h0F; sub = 0;
        @(posedge CLK);
        @(negedge CLK); start = 0;
        repeat (3) @(posedge CLK);
        #3 RST = 1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_sum", sum, 0);
        chk("arst_cout", cout, 0);
        base = done_cnt;
        @(negedge CLK); RST = 0;
        repeat (12) @(posedge CLK);
        #1;
        chk("arst_no_done", done_cnt - base, 0);
        chk("arst_idle", busy, 0);
        run_vec(vt[0], "post_rst");

        // start held high: back-to-back accepts every W+2 cycles.
        k = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge CLK);
            if (t <= 2 * (W + 2)) begin
                start = 1;
                op_a = hv[t / (W + 2)].a;
                op_b = hv[t / (W + 2)].b;
                sub  = hv[t / (W + 2)].s;
            end else begin
                start = 0;
            end
            @(posedge CLK); #1;
            if (done) begin
                if (k < 3) begin
                    chk($sformatf("held%0d_time", k), t, W + k * (W + 2));
                    chk($sformatf("held%0d_sum", k), sum, hv[k].exp_sum);
                    chk($sformatf("held%0d_cout", k), cout, hv[k].exp_cout);
                end
                k++;
            end
        end
        chk("held_count", k, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial add/subtract controller that time-multiplexes one 1-bit full-adder slice (two half-adder stages plus carry OR) across WIDTH cycles to produce a WIDTH-bit result.
- Sequences operand shift registers, the carry flop and the result shift register under a start/busy/done handshake.
- Serves as the low-area arithmetic unit for small control blocks in the tutorial datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- start  input  1  request pulse/level; accepted only in IDLE.
- sub  input  1  0 = add (A+B), 1 = subtract (A-B); sampled with start.
- op_a  input  WIDTH  operand A; sampled with start.
- op_b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result, mod 2^WIDTH.
- cout  output  1  final carry-out (for subtract: 1 = no borrow).

Behaviour:
- Interface: one clock, CLK; reset RST is asynchronous and active-high.
- Reset: state=IDLE; busy=0, done=0, sum=0, cout=0; count, carry and shift registers cleared. Reset mid-operation aborts immediately; no done pulse is issued for the aborted operation.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 at a rising edge loads shA=op_a, shB=(sub ? ~op_b : op_b), carry=sub, count=0, and moves to RUN. start=0 stays in IDLE.
  - RUN, each edge:
    - bit = shA[0]^shB[0]^carry; carry <= majority(shA[0], shB[0], carry).
    - sum <= {bit, sum[WIDTH-1:1]} (shift in at MSB).
    - shA, shB shift right by one; count++.
    - When count==WIDTH-1 at the edge, move to DONE.
  - DONE: done=1 for exactly this cycle, cout=carry; next edge returns to IDLE unconditionally.
- Latency: start sampled at edge E0 leads to done high in the cycle following edge E_WIDTH, i.e. WIDTH cycles after the accepting edge.
- Throughput: one operation per WIDTH+2 cycles. A start held high continuously is re-accepted at E_WIDTH+2.
- start while busy (RUN or DONE) is ignored and not queued. op_a, op_b and sub changes after acceptance have no effect.
- sum and cout are held stable from DONE until the next accepted start; they are intermediate/undefined-for-use during RUN.
- cout is updated only on entry to DONE; it holds its previous value during RUN.
- Arithmetic: the result equals (op_a + op_b) or (op_a + ~op_b + 1) truncated to WIDTH bits. cout is bit WIDTH of the same sum.
- count width: $clog2(WIDTH); no wrap occurs beyond WIDTH-1.
- done and busy are registered outputs, with no combinational path from inputs.

Test Plan:
- WIDTH=8, add 0x5A+0x3C, start at E0 -> busy high from E0; done pulses 8 cycles later; sum=0x96, cout=0; busy low after the DONE cycle.
- Add 0xFF+0x01 -> sum=0x00, cout=1. Then add 0x00+0x00 -> sum=0x00, cout=0 (cout correctly cleared).
- Subtract 0x10-0x01 -> sum=0x0F, cout=1. Subtract 0x01-0x02 -> sum=0xFF, cout=0.
- start pulsed again with different operands at E3 and during DONE -> ignored; result and timing match the first request only; exactly one done pulse.
- Assert RST asynchronously (mid-cycle) 4 cycles into RUN -> busy, done, sum, cout go to 0 immediately; no done pulse follows. A new start after deassertion completes normally with correct result.
- start held high for 3 operations (0x01+0x01, 0x7F+0x01, 0x80-0x80) -> done pulses spaced exactly 10 cycles apart; results 0x02/cout0, 0x80/cout0, 0x00/cout1.
